// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of a five-stage RISC-V pipeline. It owns the program
// counter, drives the chip enable and byte address of a combinational
// instruction ROM, and registers the returned instruction word together with
// its PC into the IF/ID pipeline latch read by the decode stage.
//
// A two-state FSM (BOOT, RUN) holds the ROM disabled for one cycle after
// reset. In RUN, each rising edge applies one action in priority order:
// reset, then branch redirect, then stall, then advance. A redirect loads the
// target into the PC and writes a bubble into IF/ID. A stall holds the PC and
// IF/ID. An advance captures the current fetch and steps the PC by 4.
//
// Parameters:
//   RESET_PC  PC loaded on reset. Bits [1:0] are forced to zero.
//   NOP_INST  Bubble instruction written to IF/ID on reset and on redirect.
//
// Ports:
//   clk              pipeline clock; all state changes on the rising edge
//   rst              synchronous, active-high reset
//   stall_i          hold request from the control unit
//   branch_flag_i    redirect request from the execute stage
//   branch_target_i  redirect byte address; bits [1:0] are ignored
//   rom_inst_i       ROM word for rom_addr_o, valid in the same cycle
//   rom_ce_o         ROM chip enable (1 = enabled)
//   rom_addr_o       ROM byte address, equal to the current PC
//   id_pc_o          PC of the instruction held in IF/ID
//   id_inst_o        instruction held in IF/ID
//   id_valid_o       IF/ID holds a real instruction, not a bubble
//
// Optional feature, selected by the macro IF_PERF_CNT_EN:
//   perf_fetch_cnt_o  number of advance captures, saturating
//   perf_stall_cnt_o  number of RUN cycles stalled without a redirect,
//                     saturating
// When the macro is not defined, these ports and counters do not exist.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] rom_inst_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The PC stays word-aligned, even when the reset value is misaligned.
  localparam logic [31:0] LP_RESET_PC = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] LP_CNT_MAX  = 32'hFFFF_FFFF;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_rom_ce;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  // Per-cycle action decode. Only RUN cycles have an effect. Reset is handled
  // inside the sequential block, so reset is not part of this decode.
  logic        w_run;
  logic        w_redirect;
  logic        w_hold;
  logic        w_advance;
  logic [31:0] w_pc_next_seq;
  logic [31:0] w_pc_redirect;

  // NOTE: every signal written in a combinational block gets a default value
  // first. This guarantees that no path leaves the signal unassigned, which
  // would infer a latch.
  always_comb begin
    w_run         = 1'b0;
    w_redirect    = 1'b0;
    w_hold        = 1'b0;
    w_advance     = 1'b0;
    w_pc_next_seq = r_pc + 32'd4;                       // wraps modulo 2^32
    w_pc_redirect = branch_target_i & 32'hFFFF_FFFC;   // drop byte offset
    if (r_state == ST_RUN) begin
      w_run = 1'b1;
      if (branch_flag_i) begin
        w_redirect = 1'b1;      // a redirect overrides a stall
      end else if (stall_i) begin
        w_hold = 1'b1;
      end else begin
        w_advance = 1'b1;
      end
    end
  end

  // Single sequential block for the FSM, the PC and the IF/ID latch.
  // rom_ce_o is registered. It is set on the edge that enters RUN, so the ROM
  // is enabled exactly while the FSM is in RUN.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from values sampled before the edge, which avoids
  // order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc       <= LP_RESET_PC;
      r_rom_ce   <= 1'b0;
      r_id_pc    <= 32'h0000_0000;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          // No capture in BOOT, and a redirect here is ignored. The first
          // fetch in RUN therefore always uses RESET_PC.
          r_state    <= ST_RUN;
          r_rom_ce   <= 1'b1;
          r_pc       <= LP_RESET_PC;
          r_id_pc    <= 32'h0000_0000;
          r_id_inst  <= NOP_INST;
          r_id_valid <= 1'b0;
        end
        ST_RUN: begin
          r_state  <= ST_RUN;
          r_rom_ce <= 1'b1;
          if (w_redirect) begin
            // The word fetched this cycle is on the wrong path. Replace it
            // with a bubble. The redirect costs one bubble cycle on id_*.
            r_pc       <= w_pc_redirect;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
          end else if (w_advance) begin
            r_pc       <= w_pc_next_seq;
            r_id_pc    <= r_pc;
            r_id_inst  <= rom_inst_i;
            r_id_valid <= 1'b1;
          end
          // On a stall, every register keeps its value. The same word is
          // fetched again, so a stall neither drops nor duplicates a fetch.
        end
        default: begin
          r_state    <= ST_BOOT;
          r_rom_ce   <= 1'b0;
          r_pc       <= LP_RESET_PC;
          r_id_pc    <= 32'h0000_0000;
          r_id_inst  <= NOP_INST;
          r_id_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rom_ce_o   = r_rom_ce;
  assign rom_addr_o = r_pc;
  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

`ifdef IF_PERF_CNT_EN
  // Performance counters. Each counter stops at all-ones and never wraps.
  // A redirect does not change either counter.
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0000_0000;
      r_stall_cnt <= 32'h0000_0000;
    end else begin
      if (w_advance && (r_fetch_cnt != LP_CNT_MAX)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_run && w_hold && (r_stall_cnt != LP_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Testbench for if_fetch_stage. It runs two instances in lockstep from the
// same stimulus:
//   u_dut0  RESET_PC = 0
//   u_dut1  RESET_PC = 32'hFFFF_FFFF (becomes FFFF_FFFC; checks PC wrap to 0)
//
// A behavioural model of the stage is kept for each instance. On every cycle
// the model's expected outputs go into a scoreboard queue. After the clock
// edge they are popped and compared with the instance outputs.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] ce;
    logic [31:0] addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] valid;
    logic [31:0] pf;
    logic [31:0] ps;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;

  logic        ce0, ce1, v0, v1;
  logic [31:0] addr0, addr1, ipc0, ipc1, iinst0, iinst1, rom0, rom1;
  logic [31:0] pf0, pf1, ps0, ps1;

  always #5 clk = ~clk;

  // Bench-side ROM contents. The word at address 0 is fixed; other
  // addresses hold a hash of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  always_comb rom0 = rom_word(addr0);
  always_comb rom1 = rom_word(addr1);

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) u_dut0 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .rom_inst_i(rom0),
    .rom_ce_o(ce0), .rom_addr_o(addr0), .id_pc_o(ipc0),
    .id_inst_o(iinst0), .id_valid_o(v0)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt_o(pf0), .perf_stall_cnt_o(ps0)
`endif
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .NOP_INST(NOP)) u_dut1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .rom_inst_i(rom1),
    .rom_ce_o(ce1), .rom_addr_o(addr1), .id_pc_o(ipc1),
    .id_inst_o(iinst1), .id_valid_o(v1)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt_o(pf1), .perf_stall_cnt_o(ps1)
`endif
  );

`ifndef IF_PERF_CNT_EN
  assign pf0 = 32'h0;
  assign pf1 = 32'h0;
  assign ps0 = 32'h0;
  assign ps1 = 32'h0;
`endif

  // Reference model state, one entry per instance.
  logic [31:0] m_reset_pc [2];
  bit          m_run      [2];
  logic [31:0] m_pc       [2];
  logic [31:0] m_id_pc    [2];
  logic [31:0] m_id_inst  [2];
  bit          m_valid    [2];
  logic [31:0] m_pf       [2];
  logic [31:0] m_ps       [2];

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) begin
      o.ce = {31'h0, ce0}; o.addr = addr0; o.id_pc = ipc0;
      o.id_inst = iinst0; o.valid = {31'h0, v0}; o.pf = pf0; o.ps = ps0;
    end else begin
      o.ce = {31'h0, ce1}; o.addr = addr1; o.id_pc = ipc1;
      o.id_inst = iinst1; o.valid = {31'h0, v1}; o.pf = pf1; o.ps = ps1;
    end
    return o;
  endfunction

  // Applies one clock of stimulus. The model advances, the expected
  // outputs are queued, the bench waits for the edge, and then the queue
  // is drained and compared.
  task automatic step(input bit r, input bit s, input bit b,
                      input logic [31:0] t);
    obs_t e;
    obs_t o;
    rst = r; stall_i = s; branch_flag_i = b; branch_target_i = t;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_run[k] = 0; m_pc[k] = m_reset_pc[k] & ~32'h3;
        m_id_pc[k] = 0; m_id_inst[k] = NOP; m_valid[k] = 0;
        m_pf[k] = 0; m_ps[k] = 0;
      end else if (!m_run[k]) begin
        m_run[k] = 1;
      end else if (b) begin
        m_pc[k] = {t[31:2], 2'b00};
        m_id_pc[k] = 0; m_id_inst[k] = NOP; m_valid[k] = 0;
      end else if (s) begin
        if (m_ps[k] != 32'hFFFF_FFFF) m_ps[k] = m_ps[k] + 1;
      end else begin
        m_id_pc[k] = m_pc[k]; m_id_inst[k] = rom_word(m_pc[k]);
        m_valid[k] = 1; m_pc[k] = m_pc[k] + 4;
        if (m_pf[k] != 32'hFFFF_FFFF) m_pf[k] = m_pf[k] + 1;
      end
      e.ce = {31'h0, m_run[k]}; e.addr = m_pc[k]; e.id_pc = m_id_pc[k];
      e.id_inst = m_id_inst[k]; e.valid = {31'h0, m_valid[k]};
      e.pf = m_pf[k]; e.ps = m_ps[k];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      o = observe(k);
      check($sformatf("d%0d_rom_ce", k), o.ce, e.ce);
      check($sformatf("d%0d_rom_addr", k), o.addr, e.addr);
      check($sformatf("d%0d_id_pc", k), o.id_pc, e.id_pc);
      check($sformatf("d%0d_id_inst", k), o.id_inst, e.id_inst);
      check($sformatf("d%0d_id_valid", k), o.valid, e.valid);
`ifdef IF_PERF_CNT_EN
      check($sformatf("d%0d_perf_fetch", k), o.pf, e.pf);
      check($sformatf("d%0d_perf_stall", k), o.ps, e.ps);
`endif
    end
  endtask

  initial begin
    logic [31:0] tgt;
    m_reset_pc[0] = 32'h0000_0000;
    m_reset_pc[1] = 32'hFFFF_FFFF;
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0;

    // Reset, release, boot and the first capture.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);                // BOOT -> RUN, ROM enabled at 0x0
    step(0, 0, 0, 0);                // first capture of 0x0
    step(0, 0, 0, 0);                // PC now 0x8

    // Stall for three cycles at PC 0x8, then run in a straight line.
    repeat (3) step(0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // A redirect during a stall wins and lands on the aligned target.
    step(0, 1, 1, 32'h0000_0103);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Two redirects in a row, then a straight run.
    step(0, 0, 1, 32'h0000_0040);
    step(0, 0, 1, 32'h0000_0082);
    repeat (2) step(0, 0, 0, 0);

    // Reset while stalled with a valid instruction in IF/ID.
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0300);
    // A redirect during BOOT is ignored.
    step(0, 0, 1, 32'h0000_0200);
    repeat (3) step(0, 0, 0, 0);

    // Random mix of stalls and redirects, including targets near the top of
    // the address space, so that both instances wrap.
    for (int i = 0; i < 80; i++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                        : $urandom;
      step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), tgt);
    end
    repeat (6) step(0, 0, 1, 32'hFFFF_FFF9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the program counter, drives the chip-enable and byte address of the combinational instruction ROM, and registers the returned instruction word together with its PC into the IF/ID pipeline latch consumed by the decode stage. Handles pipeline stalls from the control unit and branch/jump redirects from execute, inserting a bubble on every redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetched address.
- NOP_INST, 32'h0000_0013, bubble instruction written to IF/ID on reset and flush (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold request from control unit; freeze PC and IF/ID.
- branch_flag_i  in  1  redirect request from execute stage.
- branch_target_i  in  32  redirect byte address.
- rom_inst_i  in  32  instruction word from ROM, already byte-ordered, valid same cycle as rom_addr_o.
- rom_ce_o  out  1  ROM chip enable (1 = enabled).
- rom_addr_o  out  32  ROM byte address (= current PC).
- id_pc_o  out  32  PC of instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real (non-bubble) instruction.

## Operation
- Two-state FSM: BOOT, RUN. Reset forces BOOT; BOOT -> RUN unconditionally next cycle; RUN persists until reset.
- BOOT: rom_ce_o=0, PC=RESET_PC, IF/ID holds bubble; no capture.
- RUN: rom_ce_o=1, rom_addr_o=PC. Per edge, priority rst > branch > stall > advance:
  - branch_flag_i=1: PC <= {branch_target_i[31:2],2'b00}; IF/ID <= bubble (id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0). Overrides stall_i.
  - stall_i=1 (no branch): PC and all IF/ID outputs hold.
  - otherwise: id_pc_o <= PC, id_inst_o <= rom_inst_i, id_valid_o <= 1, PC <= PC+4.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. PC[1:0] always 2'b00; RESET_PC low bits also forced to 0.
- Branch in BOOT is ignored (no capture, FSM still enters RUN at RESET_PC).

## Timing
- Reset values: rom_ce_o=0, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0.
- Fetch latency: ROM combinational; instruction at address A appears on id_inst_o one edge after rom_addr_o=A in RUN without stall/branch.
- First valid instruction on id_* at the second rising edge after rst deasserts (edge 1: BOOT->RUN, edge 2: capture).
- Redirect penalty: one bubble cycle on id_* per taken branch; target instruction appears on id_* two edges after branch_flag_i sampled.
- Stall is level-sensitive; each stalled cycle adds exactly one hold cycle, no fetch lost or duplicated.
- rst asserted mid-run: next edge returns to reset values regardless of stall/branch.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt_o[31:0] (increments on each advance capture) and perf_stall_cnt_o[31:0] (increments each RUN cycle with stall_i=1 and branch_flag_i=0); both reset to 0, saturate at 32'hFFFF_FFFF, unaffected by branch.
- Not defined: counters and ports absent; all other behaviour identical.

## Test plan
- Reset release, RESET_PC=0, ROM word at 0x0 = 32'h0010_0093 -> cycle after deassert rom_ce_o=0; next edge rom_ce_o=1, addr 0x0; next edge id_inst_o=32'h0010_0093, id_pc_o=0, id_valid_o=1, rom_addr_o=0x4.
- Straight-line run of 8 edges -> id_pc_o steps 0x0,0x4,...,0x1C, id_inst_o matches ROM words.
- stall_i high 3 cycles at PC=0x8 -> id_* and rom_addr_o frozen 3 cycles, then resume with 0x8 captured once; perf_stall_cnt_o=3 with IF_PERF_CNT_EN.
- branch_flag_i with target 0x103 while stall_i=1 -> next edge rom_addr_o=0x100, id_valid_o=0, id_inst_o=NOP_INST; following edge id_pc_o=0x100.
- RESET_PC=32'hFFFF_FFFC -> second capture has id_pc_o=0x0 (wrap).
- rst pulsed during stall with id_valid_o=1 -> next edge all outputs at reset values, FSM in BOOT, counters 0.
